// File: rtl/alu_share_ctrl.sv
// Round-robin front end that time-shares one combinational ALU between NUM_REQ requesters.
// Optional feature macro: ALU_STATS_EN (adds a saturating 16-bit op_count of response handshakes).
module alu_share_ctrl #(
    parameter int  BUS_WIDTH = 8,
    parameter int  NUM_REQ   = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_imm,
    input  logic [NUM_REQ-1:0]             req_f_imm,
    input  logic [NUM_REQ-1:0]             req_f_add,
    output logic [BUS_WIDTH-1:0]           alu_data_a,
    output logic [BUS_WIDTH-1:0]           alu_data_b,
    output logic [BUS_WIDTH-1:0]           alu_imm,
    output logic                           alu_f_imm,
    output logic                           alu_f_add,
    input  logic [BUS_WIDTH-1:0]           alu_result,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [BUS_WIDTH-1:0]           rsp_data
`ifdef ALU_STATS_EN
    ,
    output logic [15:0]                    op_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [BUS_WIDTH-1:0] a_arr   [NUM_REQ];
    logic [BUS_WIDTH-1:0] b_arr   [NUM_REQ];
    logic [BUS_WIDTH-1:0] imm_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]   = req_a[gi*BUS_WIDTH +: BUS_WIDTH];
            assign b_arr[gi]   = req_b[gi*BUS_WIDTH +: BUS_WIDTH];
            assign imm_arr[gi] = req_imm[gi*BUS_WIDTH +: BUS_WIDTH];
        end
    endgenerate

    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_found;
    logic                 grant;

    logic [BUS_WIDTH-1:0] a_q, a_d;
    logic [BUS_WIDTH-1:0] b_q, b_d;
    logic [BUS_WIDTH-1:0] imm_q, imm_d;
    logic                 f_imm_q, f_imm_d;
    logic                 f_add_q, f_add_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [BUS_WIDTH-1:0] rsp_data_q, rsp_data_d;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin : rr_pick
        int              idx;
        logic [ID_W-1:0] sel;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = ID_W'(idx);
            if (!grant_found && req_valid[sel]) begin
                grant_found = 1'b1;
                grant_idx   = sel;
            end
        end
    end

    assign grant = (state_q == IDLE) && grant_found;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready is suppressed while reset is asserted so nothing looks accepted during reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        imm_d       = imm_q;
        f_imm_d     = f_imm_q;
        f_add_d     = f_add_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (grant) begin
            a_d      = a_arr[grant_idx];
            b_d      = b_arr[grant_idx];
            imm_d    = imm_arr[grant_idx];
            f_imm_d  = req_f_imm[grant_idx];
            f_add_d  = req_f_add[grant_idx];
            id_d     = grant_idx;
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        if (state_q == EXEC) begin
            rsp_data_d  = alu_result;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
        end
        if (state_q == RESP && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            f_imm_q     <= 1'b0;
            f_add_q     <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            f_imm_q     <= f_imm_d;
            f_add_q     <= f_add_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign alu_data_a = a_q;
    assign alu_data_b = b_q;
    assign alu_imm    = imm_q;
    assign alu_f_imm  = f_imm_q;
    assign alu_f_add  = f_add_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

`ifdef ALU_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (rsp_valid_q && rsp_ready && op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule
